alarm_scheduler: RTL and testbench

Multi-slot alarm scheduler that sits beside the adjustable HMS clock. It watches the clock's BCD hour/minute/second outputs and holds NUM_ALARMS programmable hh:mm alarm slots. When a slot matches, it drives a ring output through a ring/snooze/stop state machine. Button pulses (already debounced and single-cycle) stop or snooze the alarm; a configuration port writes the slots.

---
 rtl/alarm_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_alarm_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_scheduler
//
// Multi-slot alarm scheduler that runs beside the adjustable HMS clock. It
// holds NUM_ALARMS programmable hh:mm slots. When the clock's second rolls
// onto :00 and an enabled slot matches the current hour and minute, the
// scheduler rings. Stop and snooze buttons end the ring or postpone it.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   en_in            scheduler enable; low forces idle and blocks matching
//   bcdHour_in       current hour   (BCD 00..23)
//   bcdMinute_in     current minute (BCD 00..59)
//   bcdSecond_in     current second (BCD 00..59)
//   cfg_we_in        one-cycle slot write strobe
//   cfg_idx_in       slot to write
//   cfg_hour_in      alarm hour   (BCD)
//   cfg_minute_in    alarm minute (BCD)
//   cfg_enable_in    slot enable value to write
//   stopBtn_in       one-cycle stop pulse
//   snoozeBtn_in     one-cycle snooze pulse
//   ring_out         alarm sounding
//   ringIdx_out      slot that caused the current ring/snooze
//   snooze_out       snooze in progress
//   alarmEn_out      per-slot enable bits
//   cfgErr_out       one-cycle pulse on a rejected config write
// -----------------------------------------------------------------------------
module alarm_scheduler #(
  parameter int NUM_ALARMS     = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  localparam int IDX_W         = $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_in,
  input  logic [7:0]            bcdHour_in,
  input  logic [7:0]            bcdMinute_in,
  input  logic [7:0]            bcdSecond_in,
  input  logic                  cfg_we_in,
  input  logic [IDX_W-1:0]      cfg_idx_in,
  input  logic [7:0]            cfg_hour_in,
  input  logic [7:0]            cfg_minute_in,
  input  logic                  cfg_enable_in,
  input  logic                  stopBtn_in,
  input  logic                  snoozeBtn_in,
  output logic                  ring_out,
  output logic [IDX_W-1:0]      ringIdx_out,
  output logic                  snooze_out,
  output logic [NUM_ALARMS-1:0] alarmEn_out,
  output logic                  cfgErr_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] NUM_LIM  = (IDX_W + 1)'(NUM_ALARMS);
  localparam logic [7:0]     RING_LIM = 8'(RING_SECONDS);
  localparam logic [9:0]     SNZ_LOAD = 10'(SNOOZE_MINUTES * 60);

  // A BCD byte is legal when its low digit is 0..9 and the whole value does
  // not exceed max_v; max_v (23 or 59) already bounds the high digit.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ring_idx_q, ring_idx_d;
  logic [7:0]              ring_cnt_q, ring_cnt_d;
  logic [9:0]              snz_cnt_q, snz_cnt_d;
  logic                    ring_q, ring_d;
  logic                    snooze_q, snooze_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [7:0]              sec_prev_q, sec_prev_d;
  logic                    primed_q, primed_d;
  logic [7:0]              slot_hour_q [NUM_ALARMS];
  logic [7:0]              slot_hour_d [NUM_ALARMS];
  logic [7:0]              slot_min_q  [NUM_ALARMS];
  logic [7:0]              slot_min_d  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]   slot_en_q, slot_en_d;

  logic                    sec_tick;
  logic                    slot_hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    match;
  logic                    cfg_ok;
  logic                    kill;

  // Second tick: any change of the second value after the priming cycle,
  // so clock adjustments that jump the seconds also count as a tick.
  always_comb begin
    sec_prev_d = bcdSecond_in;
    primed_d   = 1'b1;
    sec_tick   = primed_q && (bcdSecond_in != sec_prev_q);
  end

  // Slot match on the pre-write slot contents; scanning downward leaves the
  // lowest matching index as the winner.
  always_comb begin
    slot_hit = 1'b0;
    hit_idx  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (slot_en_q[i] && (slot_hour_q[i] == bcdHour_in) &&
          (slot_min_q[i] == bcdMinute_in)) begin
        slot_hit = 1'b1;
        hit_idx  = IDX_W'(i);
      end
    end
    match = sec_tick && (bcdSecond_in == 8'h00) && en_in && slot_hit;
  end

  // Configuration port
  always_comb begin
    cfg_ok = cfg_we_in && bcd_ok(cfg_hour_in, 8'h23) &&
             bcd_ok(cfg_minute_in, 8'h59) && ({1'b0, cfg_idx_in} < NUM_LIM);
    cfg_err_d  = cfg_we_in && !cfg_ok;
    slot_hour_d = slot_hour_q;
    slot_min_d  = slot_min_q;
    slot_en_d   = slot_en_q;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (cfg_ok && (cfg_idx_in == IDX_W'(i))) begin
        slot_hour_d[i] = cfg_hour_in;
        slot_min_d[i]  = cfg_minute_in;
        slot_en_d[i]   = cfg_enable_in;
      end
    end
    // Disabling the slot that is currently ringing or snoozing cancels it.
    kill = cfg_ok && !cfg_enable_in && (cfg_idx_in == ring_idx_q) &&
           (state_q != S_IDLE);
  end

  // Ring / snooze state machine
  always_comb begin
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        ring_cnt_d = '0;
        snz_cnt_d  = '0;
        if (match) begin
          state_d    = S_RING;
          ring_idx_d = hit_idx;
        end
      end
      S_RING: begin
        if (stopBtn_in) begin
          state_d = S_IDLE;
        end else if (snoozeBtn_in) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = SNZ_LOAD;
        end else if (sec_tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_d == RING_LIM) begin
            state_d = S_IDLE;
          end
        end
      end
      S_SNOOZE: begin
        if (stopBtn_in) begin
          state_d = S_IDLE;
        end else if (sec_tick) begin
          snz_cnt_d = snz_cnt_q - 10'd1;
          if (snz_cnt_q == 10'd1) begin
            state_d    = S_RING;
            ring_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!en_in || kill) begin
      state_d    = S_IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end
    ring_d   = (state_d == S_RING);
    snooze_d = (state_d == S_SNOOZE);
  end

  // Register stage: state, counters, slots and registered outputs
  always_ff @(posedge clk) begin
    sec_prev_q <= sec_prev_d;
    if (rst) begin
      state_q    <= S_IDLE;
      ring_idx_q <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      ring_q     <= 1'b0;
      snooze_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      primed_q   <= 1'b0;
      slot_en_q  <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hour_q[i] <= 8'h00;
        slot_min_q[i]  <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      ring_idx_q  <= ring_idx_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      ring_q      <= ring_d;
      snooze_q    <= snooze_d;
      cfg_err_q   <= cfg_err_d;
      primed_q    <= primed_d;
      slot_en_q   <= slot_en_d;
      slot_hour_q <= slot_hour_d;
      slot_min_q  <= slot_min_d;
    end
  end

  assign ring_out    = ring_q;
  assign snooze_out  = snooze_q;
  assign ringIdx_out = ring_idx_q;
  assign alarmEn_out = slot_en_q;
  assign cfgErr_out  = cfg_err_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_scheduler
//
// Directed scenarios followed by a randomized phase. A behavioural model
// tracks the scheduler in terms of "ringing / snoozing / seconds left" and
// every cycle's outputs are compared with it; directed steps add literal
// expectations on top.
// -----------------------------------------------------------------------------
module tb_alarm_scheduler;

  localparam int NA = 5;
  localparam int RS = 3;
  localparam int SM = 5;
  localparam int IW = $clog2(NA);

  logic          clk = 1'b0;
  logic          rst;
  logic          en_in;
  logic [7:0]    hr, mn, sc;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [7:0]    cfg_h, cfg_m;
  logic          cfg_en;
  logic          stop_b, snz_b;
  logic          ring, snz_o, err;
  logic [IW-1:0] ridx;
  logic [NA-1:0] aen;

  alarm_scheduler #(
    .NUM_ALARMS    (NA),
    .RING_SECONDS  (RS),
    .SNOOZE_MINUTES(SM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_in        (en_in),
    .bcdHour_in   (hr),
    .bcdMinute_in (mn),
    .bcdSecond_in (sc),
    .cfg_we_in    (cfg_we),
    .cfg_idx_in   (cfg_idx),
    .cfg_hour_in  (cfg_h),
    .cfg_minute_in(cfg_m),
    .cfg_enable_in(cfg_en),
    .stopBtn_in   (stop_b),
    .snoozeBtn_in (snz_b),
    .ring_out     (ring),
    .ringIdx_out  (ridx),
    .snooze_out   (snz_o),
    .alarmEn_out  (aen),
    .cfgErr_out   (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Wall-clock time as plain integers
  int h, m, s;

  // Reference model
  bit         m_primed;
  logic [7:0] m_prev;
  logic [7:0] m_sh [NA];
  logic [7:0] m_sm [NA];
  bit         m_se [NA];
  bit         m_ringing, m_snoozing, m_err;
  int         m_idx, m_ring_left, m_snz_left;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit bcd_valid(input logic [7:0] v, input int maxv);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= maxv);
  endfunction

  function automatic logic [NA-1:0] m_en_vec();
    logic [NA-1:0] v;
    for (int i = 0; i < NA; i++) v[i] = m_se[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit tick, wr_ok, busy;
    int hit;
    if (rst) begin
      m_primed = 0; m_ringing = 0; m_snoozing = 0; m_err = 0; m_idx = 0;
      for (int i = 0; i < NA; i++) begin
        m_sh[i] = 8'h00; m_sm[i] = 8'h00; m_se[i] = 0;
      end
      return;
    end
    tick     = m_primed && (sc !== m_prev);
    m_prev   = sc;
    m_primed = 1;
    hit = -1;
    if (tick && sc == 8'h00 && en_in)
      for (int i = NA - 1; i >= 0; i--)
        if (m_se[i] && m_sh[i] == hr && m_sm[i] == mn) hit = i;
    wr_ok = cfg_we && bcd_valid(cfg_h, 23) && bcd_valid(cfg_m, 59) && (int'(cfg_idx) < NA);
    m_err = cfg_we && !wr_ok;
    busy  = m_ringing || m_snoozing;
    if (!en_in) begin
      m_ringing = 0; m_snoozing = 0;
    end else if (m_ringing) begin
      if (stop_b) m_ringing = 0;
      else if (snz_b) begin
        m_ringing = 0; m_snoozing = 1; m_snz_left = SM * 60;
      end else if (tick) begin
        m_ring_left--;
        if (m_ring_left == 0) m_ringing = 0;
      end
    end else if (m_snoozing) begin
      if (stop_b) m_snoozing = 0;
      else if (tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_snoozing = 0; m_ringing = 1; m_ring_left = RS;
        end
      end
    end else if (hit >= 0) begin
      m_ringing = 1; m_ring_left = RS; m_idx = hit;
    end
    if (busy && wr_ok && !cfg_en && int'(cfg_idx) == m_idx) begin
      m_ringing = 0; m_snoozing = 0;
    end
    if (wr_ok) begin
      m_sh[int'(cfg_idx)] = cfg_h;
      m_sm[int'(cfg_idx)] = cfg_m;
      m_se[int'(cfg_idx)] = cfg_en;
    end
  endtask

  // One clock: advance the model on the current inputs, clock the DUT,
  // compare all outputs 1 time unit after the edge, then drop pulses.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("ring_out", ring, m_ringing);
    chk("snooze_out", snz_o, m_snoozing);
    chk("ringIdx_out", ridx, m_idx);
    chk("alarmEn_out", aen, m_en_vec());
    chk("cfgErr_out", err, m_err);
    cfg_we = 0; stop_b = 0; snz_b = 0;
  endtask

  task automatic drive_time();
    hr = bcd(h); mn = bcd(m); sc = bcd(s);
  endtask

  task automatic set_hms(input int a, input int b, input int c);
    h = a; m = b; s = c;
    drive_time();
  endtask

  task automatic adv_sec();
    s++;
    if (s == 60) begin
      s = 0; m++;
      if (m == 60) begin
        m = 0; h = (h + 1) % 24;
      end
    end
    drive_time();
  endtask

  task automatic cfg_write(input int idx, input logic [7:0] hh, input logic [7:0] mm, input bit e);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_h = hh; cfg_m = mm; cfg_en = e;
    step();
  endtask

  task automatic ring_at(input int a, input int b);
    set_hms(a, b == 0 ? (a == 0 ? 23 : a) : a, 0);
    if (b == 0) set_hms(a - 1, 59, 59);
    else set_hms(a, b - 1, 59);
    step();
    set_hms(a, b, 0);
    step();
  endtask

  logic [7:0] hc [4];
  logic [7:0] mc [5];

  initial begin
    int r, pick;
    hc[0] = 8'h07; hc[1] = 8'h08; hc[2] = 8'h24; hc[3] = 8'h1A;
    mc[0] = 8'h00; mc[1] = 8'h30; mc[2] = 8'h31; mc[3] = 8'h5A; mc[4] = 8'h60;
    rst = 1; en_in = 1; cfg_we = 0; cfg_idx = '0; cfg_h = 0; cfg_m = 0; cfg_en = 0;
    stop_b = 0; snz_b = 0;
    set_hms(7, 29, 59);
    step();
    step();
    chk("rst_ring", ring, 0);
    chk("rst_snooze", snz_o, 0);
    chk("rst_idx", ridx, 0);
    chk("rst_alarmEn", aen, 0);
    chk("rst_cfgErr", err, 0);
    rst = 0;
    step();

    // Single slot rings one clock after the :00 tick
    cfg_write(0, 8'h07, 8'h30, 1);
    chk("slot0_en", aen, 5'b00001);
    chk("ring_before", ring, 0);
    set_hms(7, 30, 0);
    step();
    chk("ring_on_slot0", ring, 1);
    chk("ring_idx0", ridx, 0);
    stop_b = 1;
    step();
    chk("stop_to_idle", ring, 0);

    // Lowest matching index wins, auto-stop after RS ticks
    cfg_write(0, 8'h07, 8'h30, 0);
    cfg_write(1, 8'h07, 8'h30, 1);
    cfg_write(3, 8'h07, 8'h30, 1);
    ring_at(7, 30);
    chk("ring_on_lowest", ring, 1);
    chk("ring_idx1", ridx, 1);
    adv_sec(); step();
    adv_sec(); step();
    chk("ring_still_on", ring, 1);
    adv_sec(); step();
    chk("ring_auto_stop", ring, 0);

    // Snooze for SM minutes, then ring again on the same slot
    ring_at(7, 30);
    snz_b = 1;
    step();
    chk("snooze_on", snz_o, 1);
    chk("snooze_ring_off", ring, 0);
    for (int k = 0; k < SM * 60 - 1; k++) begin
      adv_sec(); step();
    end
    chk("snooze_holds", snz_o, 1);
    adv_sec(); step();
    chk("resnooze_ring", ring, 1);
    chk("resnooze_idx", ridx, 1);
    chk("resnooze_off", snz_o, 0);
    stop_b = 1; snz_b = 1;
    step();
    chk("stop_wins_ring", ring, 0);
    chk("stop_wins_snz", snz_o, 0);

    // Rejected configuration writes
    cfg_write(2, 8'h24, 8'h00, 1);
    chk("err_hour", err, 1);
    cfg_write(2, 8'h07, 8'h5A, 1);
    chk("err_minute", err, 1);
    cfg_write(5, 8'h07, 8'h30, 1);
    chk("err_idx", err, 1);
    cfg_write(2, 8'h07, 8'h60, 1);
    chk("err_min60", err, 1);
    chk("err_en_kept", aen, 5'b01010);
    step();
    chk("err_one_cycle", err, 0);

    // Disabling the ringing slot cancels it; en_in low ends snooze
    cfg_write(1, 8'h07, 8'h30, 0);
    cfg_write(3, 8'h07, 8'h30, 0);
    cfg_write(2, 8'h08, 8'h00, 1);
    ring_at(8, 0);
    chk("ring_slot2", ring, 1);
    chk("ring_idx2", ridx, 2);
    cfg_write(2, 8'h08, 8'h00, 0);
    chk("disable_kill", ring, 0);
    cfg_write(2, 8'h08, 8'h00, 1);
    ring_at(8, 0);
    snz_b = 1;
    step();
    chk("snooze_slot2", snz_o, 1);
    en_in = 0;
    step();
    chk("en_low_snooze", snz_o, 0);
    en_in = 1;

    // Reset while ringing, then priming cycle after release
    ring_at(8, 0);
    chk("ring_before_rst", ring, 1);
    rst = 1;
    step();
    chk("mid_rst_ring", ring, 0);
    chk("mid_rst_idx", ridx, 0);
    chk("mid_rst_en", aen, 0);
    set_hms(9, 0, 0);
    step();
    rst = 0;
    cfg_write(0, 8'h09, 8'h00, 1);
    step();
    step();
    chk("prime_no_ring", ring, 0);

    // Randomized phase
    for (int n = 0; n < 6000; n++) begin
      r = $urandom_range(0, 999);
      if (r < 400) adv_sec();
      else if (r < 412) begin
        pick = $urandom_range(0, 3);
        set_hms(7 + pick / 2, (pick % 2) != 0 ? 59 : 29, 59);
      end
      stop_b = ($urandom_range(0, 79) == 0);
      snz_b  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) begin
        cfg_we  = 1;
        cfg_idx = IW'($urandom_range(0, 7));
        cfg_h   = hc[$urandom_range(0, 3)];
        cfg_m   = mc[$urandom_range(0, 4)];
        cfg_en  = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 299) == 0) en_in = ~en_in;
      rst = ($urandom_range(0, 1999) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
